// File: rtl/mem_arbiter.sv
// Two-master (IFU/LSU) round-robin arbiter sharing one memory port, with a
// single outstanding transaction, owner-routed response and timeout abort.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_req_ready,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_resp_err,
  input  logic                ls_req_valid,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic                ls_wen,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_req_ready,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ls_resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic                mem_ren,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
  typedef enum logic {M_IF, M_LS} master_t;

  state_t              state_q;
  master_t             prio_q, owner_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   wmask_q;
  logic                if_resp_valid_q, if_resp_err_q, ls_resp_valid_q, ls_resp_err_q;
  logic [DATA_W-1:0]   if_rdata_q, ls_rdata_q;

  logic                grant_if, grant_ls, busy, timeout_hit, done, abort;
  logic [DATA_W-1:0]   resp_data;

  always_comb begin
    grant_ls    = ls_req_valid & (~if_req_valid | (prio_q == M_LS));
    grant_if    = if_req_valid & (~ls_req_valid | (prio_q == M_IF));
    busy        = (state_q == S_REQ) | (state_q == S_RESP);
    timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
    done        = (state_q == S_RESP) & mem_resp_valid;
    // completion takes precedence over a coincident timeout
    abort       = busy & timeout_hit & ~done;
    resp_data   = (done & ~wen_q) ? mem_rdata : '0;
  end

  assign if_req_ready  = (state_q == S_IDLE) & grant_if;
  assign ls_req_ready  = (state_q == S_IDLE) & grant_ls;
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_wen       = mem_req_valid & wen_q;
  assign mem_ren       = mem_req_valid & ~wen_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign if_resp_valid = if_resp_valid_q;
  assign if_resp_err   = if_resp_err_q;
  assign if_rdata      = if_rdata_q;
  assign ls_resp_valid = ls_resp_valid_q;
  assign ls_resp_err   = ls_resp_err_q;
  assign ls_rdata      = ls_rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      prio_q          <= M_LS;
      owner_q         <= M_IF;
      cnt_q           <= '0;
      addr_q          <= '0;
      wen_q           <= 1'b0;
      wdata_q         <= '0;
      wmask_q         <= '0;
      if_resp_valid_q <= 1'b0;
      if_resp_err_q   <= 1'b0;
      if_rdata_q      <= '0;
      ls_resp_valid_q <= 1'b0;
      ls_resp_err_q   <= 1'b0;
      ls_rdata_q      <= '0;
    end else begin
      if_resp_valid_q <= 1'b0;
      if_resp_err_q   <= 1'b0;
      ls_resp_valid_q <= 1'b0;
      ls_resp_err_q   <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (grant_ls) begin
            owner_q <= M_LS;
            prio_q  <= M_IF;
            addr_q  <= ls_addr;
            wen_q   <= ls_wen;
            wdata_q <= ls_wdata;
            wmask_q <= ls_wen ? ls_wmask : '0;
            cnt_q   <= '0;
            state_q <= S_REQ;
          end else if (grant_if) begin
            owner_q <= M_IF;
            prio_q  <= M_LS;
            addr_q  <= if_addr;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            cnt_q   <= '0;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (abort)              state_q <= S_IDLE;
          else if (mem_req_ready) state_q <= S_RESP;
        end
        S_RESP: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (done | abort) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (done | abort) begin
        if (owner_q == M_LS) begin
          ls_resp_valid_q <= 1'b1;
          ls_resp_err_q   <= abort;
          ls_rdata_q      <= resp_data;
        end else begin
          if_resp_valid_q <= 1'b1;
          if_resp_err_q   <= abort;
          if_rdata_q      <= resp_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset abandon, IFU read, round-robin,
// held LSU write and timeout with a late ignored response (TIMEOUT=8).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_err;
  logic [31:0] if_addr;
  logic [63:0] if_rdata;
  logic        ls_req_valid, ls_wen, ls_req_ready, ls_resp_valid, ls_resp_err;
  logic [31:0] ls_addr;
  logic [63:0] ls_wdata, ls_rdata;
  logic [7:0]  ls_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_ren, mem_resp_valid;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  int n_checks = 0;
  int n_fails  = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_addr(if_addr), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_rdata(if_rdata), .if_resp_err(if_resp_err),
    .ls_req_valid(ls_req_valid), .ls_addr(ls_addr), .ls_wen(ls_wen),
    .ls_wdata(ls_wdata), .ls_wmask(ls_wmask), .ls_req_ready(ls_req_ready),
    .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata), .ls_resp_err(ls_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    if_req_valid = 1'b0; if_addr = '0;
    ls_req_valid = 1'b0; ls_addr = '0; ls_wen = 1'b0; ls_wdata = '0; ls_wmask = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    tick(); tick();
    n_checks++; if (mem_req_valid !== 1'b0) begin n_fails++; $error("FAIL rst_mem_req_valid: observed %0h expected 0", mem_req_valid); end
    n_checks++; if (mem_wmask !== 8'h00) begin n_fails++; $error("FAIL rst_mem_wmask: observed %0h expected 0", mem_wmask); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fails++; $error("FAIL rst_mem_addr: observed %0h expected 0", mem_addr); end
    n_checks++; if (if_resp_valid !== 1'b0) begin n_fails++; $error("FAIL rst_if_resp_valid: observed %0h expected 0", if_resp_valid); end
    n_checks++; if (ls_rdata !== 64'h0) begin n_fails++; $error("FAIL rst_ls_rdata: observed %0h expected 0", ls_rdata); end
    rst = 1'b0;
    tick();

    // Reset while in REQ
    ls_req_valid = 1'b1; ls_addr = 32'h8000_0000; ls_wen = 1'b0;
    #1;
    n_checks++; if (ls_req_ready !== 1'b1) begin n_fails++; $error("FAIL r1_ls_ready: observed %0h expected 1", ls_req_ready); end
    n_checks++; if (if_req_ready !== 1'b0) begin n_fails++; $error("FAIL r1_if_ready: observed %0h expected 0", if_req_ready); end
    tick();
    ls_req_valid = 1'b0;
    n_checks++; if (mem_req_valid !== 1'b1) begin n_fails++; $error("FAIL r1_mem_req_valid: observed %0h expected 1", mem_req_valid); end
    n_checks++; if (mem_addr !== 32'h8000_0000) begin n_fails++; $error("FAIL r1_mem_addr: observed %0h expected 80000000", mem_addr); end
    n_checks++; if (mem_ren !== 1'b1) begin n_fails++; $error("FAIL r1_mem_ren: observed %0h expected 1", mem_ren); end
    tick();
    n_checks++; if (mem_req_valid !== 1'b1) begin n_fails++; $error("FAIL r1_hold_valid: observed %0h expected 1", mem_req_valid); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (mem_req_valid !== 1'b0) begin n_fails++; $error("FAIL r1_async_drop: observed %0h expected 0", mem_req_valid); end
    tick();
    rst = 1'b0;
    tick();
    n_checks++; if (ls_resp_valid !== 1'b0) begin n_fails++; $error("FAIL r1_no_ls_resp: observed %0h expected 0", ls_resp_valid); end
    n_checks++; if (if_resp_valid !== 1'b0) begin n_fails++; $error("FAIL r1_no_if_resp: observed %0h expected 0", if_resp_valid); end
    if_req_valid = 1'b1; if_addr = 32'h0000_0100;
    ls_req_valid = 1'b1; ls_addr = 32'h0000_0200;
    #1;
    n_checks++; if (ls_req_ready !== 1'b1) begin n_fails++; $error("FAIL r1_post_ls_ready: observed %0h expected 1", ls_req_ready); end
    n_checks++; if (if_req_ready !== 1'b0) begin n_fails++; $error("FAIL r1_post_if_ready: observed %0h expected 0", if_req_ready); end
    tick();
    if_req_valid = 1'b0; ls_req_valid = 1'b0; mem_req_ready = 1'b1;
    n_checks++; if (mem_addr !== 32'h0000_0200) begin n_fails++; $error("FAIL r1_post_addr: observed %0h expected 200", mem_addr); end
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 64'hAAAA_0000_BBBB_1111;
    tick();
    mem_resp_valid = 1'b0;
    n_checks++; if (ls_resp_valid !== 1'b1) begin n_fails++; $error("FAIL r1_post_ls_resp: observed %0h expected 1", ls_resp_valid); end
    n_checks++; if (ls_rdata !== 64'hAAAA_0000_BBBB_1111) begin n_fails++; $error("FAIL r1_post_ls_rdata: observed %0h expected aaaa0000bbbb1111", ls_rdata); end
    n_checks++; if (if_resp_valid !== 1'b0) begin n_fails++; $error("FAIL r1_post_if_resp: observed %0h expected 0", if_resp_valid); end
    tick();

    // IFU read, memory ready immediately
    if_req_valid = 1'b1; if_addr = 32'h8000_0000;
    #1;
    n_checks++; if (if_req_ready !== 1'b1) begin n_fails++; $error("FAIL if_ready: observed %0h expected 1", if_req_ready); end
    tick();
    if_req_valid = 1'b0; mem_req_ready = 1'b1;
    n_checks++; if (mem_req_valid !== 1'b1) begin n_fails++; $error("FAIL if_mem_valid: observed %0h expected 1", mem_req_valid); end
    n_checks++; if (mem_addr !== 32'h8000_0000) begin n_fails++; $error("FAIL if_mem_addr: observed %0h expected 80000000", mem_addr); end
    n_checks++; if (mem_wen !== 1'b0) begin n_fails++; $error("FAIL if_mem_wen: observed %0h expected 0", mem_wen); end
    n_checks++; if (mem_wmask !== 8'h00) begin n_fails++; $error("FAIL if_mem_wmask: observed %0h expected 0", mem_wmask); end
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 64'h0010_0073_0000_0013;
    n_checks++; if (if_resp_valid !== 1'b0) begin n_fails++; $error("FAIL if_resp_early: observed %0h expected 0", if_resp_valid); end
    n_checks++; if (mem_req_valid !== 1'b0) begin n_fails++; $error("FAIL if_mem_valid_resp: observed %0h expected 0", mem_req_valid); end
    tick();
    mem_resp_valid = 1'b0;
    n_checks++; if (if_resp_valid !== 1'b1) begin n_fails++; $error("FAIL if_resp_valid: observed %0h expected 1", if_resp_valid); end
    n_checks++; if (if_rdata !== 64'h0010_0073_0000_0013) begin n_fails++; $error("FAIL if_rdata: observed %0h expected 10007300000013", if_rdata); end
    n_checks++; if (if_resp_err !== 1'b0) begin n_fails++; $error("FAIL if_resp_err: observed %0h expected 0", if_resp_err); end
    n_checks++; if (ls_resp_valid !== 1'b0) begin n_fails++; $error("FAIL if_ls_quiet: observed %0h expected 0", ls_resp_valid); end
    tick();
    n_checks++; if (if_resp_valid !== 1'b0) begin n_fails++; $error("FAIL if_pulse_end: observed %0h expected 0", if_resp_valid); end

    // Simultaneous requests, three rounds: LSU, IFU, LSU
    if_req_valid = 1'b1; if_addr = 32'h0000_1000;
    ls_req_valid = 1'b1; ls_addr = 32'h0000_2000; ls_wen = 1'b0;
    for (int unsigned r = 0; r < 3; r++) begin
      logic        exp_ls;
      logic [31:0] exp_addr;
      exp_ls   = (r != 1);
      exp_addr = exp_ls ? 32'h0000_2000 : 32'h0000_1000;
      #1;
      n_checks++; if (ls_req_ready !== exp_ls) begin n_fails++; $error("FAIL rr_ls_ready: observed %0h expected %0h", ls_req_ready, exp_ls); end
      n_checks++; if (if_req_ready !== ~exp_ls) begin n_fails++; $error("FAIL rr_if_ready: observed %0h expected %0h", if_req_ready, ~exp_ls); end
      tick();
      mem_req_ready = 1'b1;
      n_checks++; if (ls_req_ready !== 1'b0) begin n_fails++; $error("FAIL rr_busy_ls_ready: observed %0h expected 0", ls_req_ready); end
      n_checks++; if (if_req_ready !== 1'b0) begin n_fails++; $error("FAIL rr_busy_if_ready: observed %0h expected 0", if_req_ready); end
      n_checks++; if (mem_addr !== exp_addr) begin n_fails++; $error("FAIL rr_addr: observed %0h expected %0h", mem_addr, exp_addr); end
      tick();
      mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 64'h0000_0000_0000_00A0 + 64'(r);
      tick();
      mem_resp_valid = 1'b0;
      n_checks++; if (ls_resp_valid !== exp_ls) begin n_fails++; $error("FAIL rr_ls_resp: observed %0h expected %0h", ls_resp_valid, exp_ls); end
      n_checks++; if (if_resp_valid !== ~exp_ls) begin n_fails++; $error("FAIL rr_if_resp: observed %0h expected %0h", if_resp_valid, ~exp_ls); end
    end
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    tick();

    // LSU write, memory ready delayed 4 cycles
    ls_req_valid = 1'b1; ls_wen = 1'b1; ls_addr = 32'h8000_1000;
    ls_wdata = 64'h1122_3344_5566_7788; ls_wmask = 8'hFF;
    #1;
    n_checks++; if (ls_req_ready !== 1'b1) begin n_fails++; $error("FAIL wr_ready: observed %0h expected 1", ls_req_ready); end
    tick();
    ls_req_valid = 1'b0; ls_wen = 1'b0; ls_addr = 32'hDEAD_0000;
    ls_wdata = 64'hFFFF_FFFF_FFFF_FFFF; ls_wmask = 8'h0F;
    for (int unsigned c = 0; c < 4; c++) begin
      n_checks++; if (mem_req_valid !== 1'b1) begin n_fails++; $error("FAIL wr_valid: observed %0h expected 1", mem_req_valid); end
      n_checks++; if (mem_addr !== 32'h8000_1000) begin n_fails++; $error("FAIL wr_addr: observed %0h expected 80001000", mem_addr); end
      n_checks++; if (mem_wdata !== 64'h1122_3344_5566_7788) begin n_fails++; $error("FAIL wr_wdata: observed %0h expected 1122334455667788", mem_wdata); end
      n_checks++; if (mem_wmask !== 8'hFF) begin n_fails++; $error("FAIL wr_wmask: observed %0h expected ff", mem_wmask); end
      n_checks++; if (mem_wen !== 1'b1) begin n_fails++; $error("FAIL wr_wen: observed %0h expected 1", mem_wen); end
      n_checks++; if (mem_ren !== 1'b0) begin n_fails++; $error("FAIL wr_ren: observed %0h expected 0", mem_ren); end
      tick();
    end
    mem_req_ready = 1'b1;
    n_checks++; if (mem_req_valid !== 1'b1) begin n_fails++; $error("FAIL wr_valid_at_ready: observed %0h expected 1", mem_req_valid); end
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 64'hCAFE_F00D_CAFE_F00D;
    tick();
    mem_resp_valid = 1'b0;
    n_checks++; if (ls_resp_valid !== 1'b1) begin n_fails++; $error("FAIL wr_ls_resp: observed %0h expected 1", ls_resp_valid); end
    n_checks++; if (ls_rdata !== 64'h0) begin n_fails++; $error("FAIL wr_ls_rdata: observed %0h expected 0", ls_rdata); end
    n_checks++; if (ls_resp_err !== 1'b0) begin n_fails++; $error("FAIL wr_ls_err: observed %0h expected 0", ls_resp_err); end
    tick();

    // Timeout: accepted by memory, never answered
    ls_req_valid = 1'b1; ls_wen = 1'b0; ls_addr = 32'h8000_2000;
    #1;
    n_checks++; if (ls_req_ready !== 1'b1) begin n_fails++; $error("FAIL to_ready: observed %0h expected 1", ls_req_ready); end
    tick();
    ls_req_valid = 1'b0; mem_req_ready = 1'b1;
    n_checks++; if (mem_req_valid !== 1'b1) begin n_fails++; $error("FAIL to_enter_req: observed %0h expected 1", mem_req_valid); end
    for (int unsigned c = 1; c <= 8; c++) begin
      n_checks++; if (ls_resp_valid !== 1'b0) begin n_fails++; $error("FAIL to_no_resp_yet: observed %0h expected 0", ls_resp_valid); end
      tick();
      mem_req_ready = 1'b0;
    end
    n_checks++; if (ls_resp_valid !== 1'b1) begin n_fails++; $error("FAIL to_resp_valid: observed %0h expected 1", ls_resp_valid); end
    n_checks++; if (ls_resp_err !== 1'b1) begin n_fails++; $error("FAIL to_resp_err: observed %0h expected 1", ls_resp_err); end
    n_checks++; if (ls_rdata !== 64'h0) begin n_fails++; $error("FAIL to_rdata: observed %0h expected 0", ls_rdata); end
    n_checks++; if (if_resp_valid !== 1'b0) begin n_fails++; $error("FAIL to_if_quiet: observed %0h expected 0", if_resp_valid); end
    tick();
    n_checks++; if (ls_resp_valid !== 1'b0) begin n_fails++; $error("FAIL to_pulse_end: observed %0h expected 0", ls_resp_valid); end
    n_checks++; if (ls_resp_err !== 1'b0) begin n_fails++; $error("FAIL to_err_end: observed %0h expected 0", ls_resp_err); end
    mem_resp_valid = 1'b1; mem_rdata = 64'h0000_0000_0000_0BAD;
    tick();
    mem_resp_valid = 1'b0;
    n_checks++; if (ls_resp_valid !== 1'b0) begin n_fails++; $error("FAIL to_late_ls: observed %0h expected 0", ls_resp_valid); end
    n_checks++; if (if_resp_valid !== 1'b0) begin n_fails++; $error("FAIL to_late_if: observed %0h expected 0", if_resp_valid); end
    n_checks++; if (mem_req_valid !== 1'b0) begin n_fails++; $error("FAIL to_idle: observed %0h expected 0", mem_req_valid); end
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, one-port memory arbiter and transaction sequencer for the LemonPC core. It shares the single external memory port between instruction fetch (IFU) and load/store (LSU). It grants one request at a time under round-robin priority and holds the request until the memory accepts it. It then routes the single response back to the owning master, and aborts with an error if memory stalls beyond a timeout.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 64: data width. Mask width is `DATA_W/8`.
- `TIMEOUT`, 1023: maximum cycles a transaction may spend in REQ plus RESP before abort. Must be ≥2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `if_req_valid`  in  1  IFU read request.
- `if_addr`  in  ADDR_W  IFU fetch address.
- `if_req_ready`  out  1  IFU request accepted this cycle.
- `if_resp_valid`  out  1  one-cycle IFU response pulse.
- `if_rdata`  out  DATA_W  IFU read data.
- `if_resp_err`  out  1  IFU response is a timeout.
- `ls_req_valid`  in  1  LSU request.
- `ls_addr`  in  ADDR_W  LSU address.
- `ls_wen`  in  1  1 = write, 0 = read.
- `ls_wdata`  in  DATA_W  write data.
- `ls_wmask`  in  DATA_W/8  byte write mask.
- `ls_req_ready`  out  1  LSU request accepted this cycle.
- `ls_resp_valid`  out  1  one-cycle LSU response pulse.
- `ls_rdata`  out  DATA_W  LSU read data; 0 for writes.
- `ls_resp_err`  out  1  LSU response is a timeout.
- `mem_req_valid`  out  1  request to memory.
- `mem_req_ready`  in  1  memory accepts request.
- `mem_addr`  out  ADDR_W  latched address.
- `mem_wen`  out  1  `mem_req_valid & latched wen`.
- `mem_ren`  out  1  `mem_req_valid & ~latched wen`.
- `mem_wdata`  out  DATA_W  latched write data.
- `mem_wmask`  out  DATA_W/8  latched mask; 0 for reads and IFU.
- `mem_resp_valid`  in  1  memory response; one per accepted request, reads and writes alike.
- `mem_rdata`  in  DATA_W  memory read data.

## Operation
- FSM states:
  - IDLE: no transaction outstanding.
  - REQ: `mem_req_valid`=1, waiting for `mem_req_ready`.
  - RESP: waiting for `mem_resp_valid`.
- Grant, combinational in IDLE only:
  - If only one master is valid, that master is granted.
  - If both are valid, the master indicated by priority pointer `prio` is granted.
  - `x_req_ready` = IDLE & `x_req_valid` & granted. Outside IDLE both readies are 0.
- On a handshake in IDLE:
  - Latch addr, wen (IFU forces 0), wdata, and mask (IFU or read forces 0).
  - Latch `owner`.
  - Set `prio` to the other master.
  - Clear the timeout counter.
  - Go to REQ.
- REQ:
  - Outputs are driven only from latched registers and are stable until `mem_req_ready`.
  - Go to RESP when `mem_req_ready`=1.
- RESP:
  - When `mem_resp_valid`=1, register the response to the owner: `resp_valid`=1, rdata = `mem_rdata` (0 if write), err=0.
  - Go to IDLE.
- Timeout:
  - `cnt` increments every cycle in REQ or RESP. Width is `clog2(TIMEOUT+1)`.
  - If `cnt` == `TIMEOUT-1` and the transaction does not complete that cycle: owner gets `resp_valid`=1, err=1, rdata=0; go to IDLE.
  - If completion and timeout fall in the same cycle, completion wins.
- `mem_resp_valid` outside RESP is ignored, including a late response after a timeout.
- Never more than one outstanding transaction. `resp_valid` is never asserted to a non-owner.

## Timing
- Reset values:
  - state = IDLE, `prio` = LSU, `cnt` = 0.
  - All latched data = 0.
  - All `*_resp_valid`, `*_resp_err`, `*_rdata` = 0.
  - `mem_req_valid`/`mem_wen`/`mem_ren`/`mem_wmask` = 0.
- Reset mid-transaction abandons it with no response pulse.
- Latency, with the handshake at cycle T:
  - T+1: `mem_req_valid` asserted.
  - If ready at T+1: RESP at T+2.
  - If `mem_resp_valid` at T+2: owner `resp_valid` at T+3.
  - Minimum accept-to-response is 3 cycles.
- At T+3 the FSM is IDLE, so a new request can be accepted in the same cycle as the response pulse.
- `resp_valid` is a single-cycle pulse. Masters must not need backpressure on responses.
- Timeout fires at most `TIMEOUT` cycles after entering REQ.

## Test plan
- Reset while in REQ:
  - Stimulus: LSU read to 0x80000000, `mem_req_ready`=0, `rst` pulsed.
  - Response: `mem_req_valid` drops immediately; no response pulse; next simultaneous request grants LSU.
- IFU read, memory ready immediately:
  - Stimulus: `if_addr`=0x80000000, `mem_rdata`=0x00100073_00000013, response 1 cycle after accept.
  - Response: `if_resp_valid` at T+3 with that data, `if_resp_err`=0.
- Simultaneous requests, 3 rounds:
  - Stimulus: IFU and LSU both held valid.
  - Response: grants LSU, IFU, LSU, in order.
- LSU write:
  - Stimulus: `ls_wen`=1, addr 0x80001000, wdata 0x1122334455667788, mask 0xFF; `mem_req_ready` delayed 4 cycles.
  - Response: `mem_*` stable throughout the wait, `mem_wen`=1, `mem_ren`=0; `ls_rdata`=0 on response.
- Timeout:
  - Stimulus: `TIMEOUT`=8, memory never responds.
  - Response: `ls_resp_err`=1 exactly 8 cycles after entering REQ; a later `mem_resp_valid` is ignored.
